register_file: RTL and testbench

//   Parametrised multi-entry register file: DEPTH words of WIDTH bits, one synchronous write

---
 rtl/register_file.sv | 129 ++++++++++++
 tb/tb_register_file.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// rtl/register_file.sv - DEPTH x WIDTH register file, one write port, two combinational read ports
//
// Purpose: the array has no reset of its own. After reset, a hardware sweep writes zero
// to every entry, one entry per clock. Writes are accepted only after the sweep completes.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high; restarts the clear sweep
//   write        write enable; takes effect only while ready=1
//   write_addr   write address; out-of-range writes are dropped
//   d            write data
//   read_addr_a  read port A address; out-of-range reads return 0
//   q_a          read port A data (combinational)
//   read_addr_b  read port B address; out-of-range reads return 0
//   q_b          read port B data (combinational)
//   ready        1 = sweep complete, writes accepted, reads valid
//
// Option: define REGISTER_FILE_BYPASS_EN to forward d to a read port in the same cycle,
// when that port addresses the entry being written.
module register_file #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [WIDTH-1:0]      d,
  input  logic [ADDR_WIDTH-1:0] read_addr_a,
  output logic [WIDTH-1:0]      q_a,
  input  logic [ADDR_WIDTH-1:0] read_addr_b,
  output logic [WIDTH-1:0]      q_b,
  output logic                  ready
);

  typedef enum logic {CLEAR, RUN} state_t;

  // DEPTH needs one extra bit when it is a power of two.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < DEPTH_EXT;
  endfunction

  // No reset term, so the array can map onto LUT RAM.
  logic [WIDTH-1:0] mem [0:DEPTH-1];

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clear_addr, clear_addr_next;
  logic                  ready_next;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= CLEAR;
      clear_addr <= '0;
      ready      <= 1'b0;
    end else begin
      state      <= state_next;
      clear_addr <= clear_addr_next;
      ready      <= ready_next;
    end
  end

  // The sweep and user writes share the single array write port. Reset gates both,
  // so reset wins over a simultaneous write.
  always_comb begin
    state_next      = state;
    clear_addr_next = clear_addr;
    ready_next      = ready;
    mem_we          = 1'b0;
    mem_waddr       = write_addr;
    mem_wdata       = d;
    if (!reset) begin
      case (state)
        CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = clear_addr;
          mem_wdata = '0;
          if (clear_addr == LAST_ADDR) begin
            state_next      = RUN;
            ready_next      = 1'b1;
            clear_addr_next = '0;
          end else begin
            clear_addr_next = clear_addr + 1'b1;
          end
        end
        RUN: begin
          if (write && in_range(write_addr)) mem_we = 1'b1;
        end
        default: begin
          state_next = CLEAR;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  logic [WIDTH-1:0] stored_a, stored_b;

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    if (in_range(read_addr_a)) stored_a = mem[read_addr_a];
    if (in_range(read_addr_b)) stored_b = mem[read_addr_b];
  end

`ifdef REGISTER_FILE_BYPASS_EN
  logic fwd_ok;
  always_comb begin
    fwd_ok = write && ready && in_range(write_addr);
    q_a    = (fwd_ok && read_addr_a == write_addr) ? d : stored_a;
    q_b    = (fwd_ok && read_addr_b == write_addr) ? d : stored_b;
  end
`else
  always_comb begin
    q_a = stored_a;
    q_b = stored_b;
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file (DEPTH=16 and DEPTH=12 instances)
module tb_register_file;

  logic       clock = 1'b0;
  logic       reset = 1'b0;

  // DEPTH=16 instance
  logic       write = 1'b0;
  logic [3:0] write_addr = '0;
  logic [7:0] d = '0;
  logic [3:0] read_addr_a = '0;
  logic [3:0] read_addr_b = '0;
  logic [7:0] q_a, q_b;
  logic       ready;

  // DEPTH=12 instance
  logic       write12 = 1'b0;
  logic [3:0] write_addr12 = '0;
  logic [7:0] d12 = '0;
  logic [3:0] read_addr_a12 = '0;
  logic [3:0] read_addr_b12 = '0;
  logic [7:0] q_a12, q_b12;
  logic       ready12;

  register_file #(.WIDTH(8), .DEPTH(16)) dut (
    .clock(clock), .reset(reset), .write(write), .write_addr(write_addr), .d(d),
    .read_addr_a(read_addr_a), .q_a(q_a), .read_addr_b(read_addr_b), .q_b(q_b),
    .ready(ready)
  );

  register_file #(.WIDTH(8), .DEPTH(12)) dut12 (
    .clock(clock), .reset(reset), .write(write12), .write_addr(write_addr12), .d(d12),
    .read_addr_a(read_addr_a12), .q_a(q_a12), .read_addr_b(read_addr_b12), .q_b(q_b12),
    .ready(ready12)
  );

  always #5 clock = ~clock;

  // sel: 0 = ready, 1 = q_a, 2 = q_b ; dut: 0 = DEPTH 16, 1 = DEPTH 12
  typedef struct {
    string      name;
    int         dut;
    int         sel;
    logic [7:0] exp;
  } item_t;

  item_t sb[$];
  int    n_tests = 0;
  int    n_failed = 0;

  task automatic expect_val(input string name, input int dut_sel, input int sel, input logic [7:0] v);
    item_t it;
    it.name = name;
    it.dut  = dut_sel;
    it.sel  = sel;
    it.exp  = v;
    sb.push_back(it);
  endtask

  task automatic check_now(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_failed++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; the monitor samples at the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    while (sb.size() > 0) begin
      item_t      it;
      logic [7:0] act;
      it = sb.pop_front();
      if (it.dut == 0) act = (it.sel == 0) ? {7'd0, ready}   : (it.sel == 1) ? q_a   : q_b;
      else             act = (it.sel == 0) ? {7'd0, ready12} : (it.sel == 1) ? q_a12 : q_b12;
      n_tests++;
      if (act !== it.exp) begin
        n_failed++;
        $display("FAIL %s: got %02h expected %02h", it.name, act, it.exp);
      end
    end
  end

  logic [7:0] rdw_exp;

  initial begin
`ifdef REGISTER_FILE_BYPASS_EN
    rdw_exp = 8'h22;
`else
    rdw_exp = 8'h11;
`endif
    step();

    // Clear sweep; a write during the sweep (sweep cycle 5) must be dropped.
    reset = 1'b1;
    step();
    check_now("reset_state16", {7'd0, ready}, 8'd0);
    check_now("reset_state12", {7'd0, ready12}, 8'd0);
    expect_val("reset_ready16", 0, 0, 8'd0);
    expect_val("reset_ready12", 1, 0, 8'd0);
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      // k rising edges with reset low have occurred so far
      expect_val("sweep_ready16", 0, 0, 8'd0);
      expect_val("sweep_ready12", 1, 0, (k >= 12) ? 8'd1 : 8'd0);
      write      = (k == 5);
      write_addr = 4'd0;
      d          = 8'hFF;
      step();
    end
    write = 1'b0;
    check_now("wait_expired16", {7'd0, ready}, 8'd1);
    expect_val("sweep_done16", 0, 0, 8'd1);
    for (int a = 0; a < 16; a++) begin
      read_addr_a = 4'(a);
      read_addr_b = 4'(15 - a);
      expect_val("cleared_a", 0, 1, 8'h00);
      expect_val("cleared_b", 0, 2, 8'h00);
      step();
    end

    // Write and read back on both ports.
    write = 1'b1; write_addr = 4'd3;  d = 8'hA5; step();
    write = 1'b1; write_addr = 4'd15; d = 8'h5A; step();
    write = 1'b0;
    read_addr_a = 4'd3; read_addr_b = 4'd15;
    expect_val("wr3_a", 0, 1, 8'hA5);
    expect_val("wr15_b", 0, 2, 8'h5A);
    step();
    read_addr_a = 4'd4; read_addr_b = 4'd14;
    expect_val("other_a", 0, 1, 8'h00);
    expect_val("other_b", 0, 2, 8'h00);
    step();
    read_addr_a = 4'd15; read_addr_b = 4'd3;
    expect_val("swap_a", 0, 1, 8'h5A);
    expect_val("swap_b", 0, 2, 8'hA5);
    step();

    // Read-during-write at address 7: old 11, new 22.
    write = 1'b1; write_addr = 4'd7; d = 8'h11; step();
    write = 1'b1; write_addr = 4'd7; d = 8'h22;
    read_addr_a = 4'd7; read_addr_b = 4'd7;
    expect_val("rdw_same_a", 0, 1, rdw_exp);
    expect_val("rdw_same_b", 0, 2, rdw_exp);
    step();
    write = 1'b0;
    expect_val("rdw_next_a", 0, 1, 8'h22);
    expect_val("rdw_next_b", 0, 2, 8'h22);
    step();

    // Out-of-range on DEPTH=12: write 13 dropped, read 13 gives 0; in-range write still works.
    write12 = 1'b1; write_addr12 = 4'd13; d12 = 8'h3C; step();
    write12 = 1'b1; write_addr12 = 4'd11; d12 = 8'hC3; step();
    write12 = 1'b0;
    for (int a = 0; a < 16; a++) begin
      read_addr_a12 = 4'(a);
      read_addr_b12 = 4'(a);
      expect_val("d12_a", 1, 1, (a == 11) ? 8'hC3 : 8'h00);
      expect_val("d12_b", 1, 2, (a == 11) ? 8'hC3 : 8'h00);
      step();
    end

    // Reset in RUN with mem[3]=A5, a simultaneous write is dropped; then reset mid-sweep.
    write = 1'b1; write_addr = 4'd5; d = 8'h77;
    reset = 1'b1;
    expect_val("run_ready", 0, 0, 8'd1);
    step();
    write = 1'b0;
    check_now("rst_state16", {7'd0, ready}, 8'd0);
    expect_val("rst_ready", 0, 0, 8'd0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      expect_val("sweep2_ready", 0, 0, 8'd0);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      expect_val("sweep3_ready", 0, 0, 8'd0);
      step();
    end
    check_now("wait3_expired16", {7'd0, ready}, 8'd1);
    expect_val("sweep3_done", 0, 0, 8'd1);
    read_addr_a = 4'd3; read_addr_b = 4'd5;
    expect_val("rerun_3", 0, 1, 8'h00);
    expect_val("rerun_5", 0, 2, 8'h00);
    step();
    read_addr_a = 4'd7; read_addr_b = 4'd15;
    expect_val("rerun_7", 0, 1, 8'h00);
    expect_val("rerun_15", 0, 2, 8'h00);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
